// File: rtl/clock_pkg.sv
// Shared definitions for the core clock run/halt/step sequencer.
// State encoding is visible on the debug port, so it is fixed here once.
package clock_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    STATE_HALTED = 2'd0,
    STATE_RUN    = 2'd1,
    STATE_STEP   = 2'd2
  } state_t;

  // The clock-enable is asserted exactly in the states that let the core advance.
  function automatic logic state_enables(input state_t s);
    return (s == STATE_RUN) || (s == STATE_STEP);
  endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter holding the remaining length of a step burst.
// o_last flags the final cycle of the burst (remaining == 1).
module step_counter
  import clock_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_load,
  input  logic [COUNT_WIDTH-1:0] i_value,
  input  logic                   i_dec,
  output logic                   o_last
);

  logic [COUNT_WIDTH-1:0] r_remaining;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_remaining <= '0;
    end else if (i_load) begin
      r_remaining <= i_value;
    end else if (i_dec) begin
      r_remaining <= r_remaining - COUNT_WIDTH'(1);
    end
  end

  assign o_last = (r_remaining == COUNT_WIDTH'(1));

endmodule

// File: rtl/clock_controller.sv
// Run/halt/single-step sequencer producing a registered core clock-enable,
// with breakpoint handling and a wrapping count of enabled cycles.
module clock_controller
  import clock_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_run,
  input  logic                   i_halt,
  input  logic                   i_step,
  input  logic [COUNT_WIDTH-1:0] i_step_count,
  input  logic                   i_break,
  input  logic                   i_clear,
  output logic                   o_enable,
  output logic                   o_done,
  output logic [STATE_W-1:0]     o_state,
  output logic [CYCLE_WIDTH-1:0] o_cycles
);

  // Command interface: i_run/i_halt/i_step/i_clear are single-cycle pulses
  // sampled on every rising edge; there is no ready, so every cycle accepts one.
  state_t                 r_state;
  logic                   r_enable;
  logic                   r_done;
  logic [CYCLE_WIDTH-1:0] r_cycles;

  state_t                 w_state_next;
  logic                   w_done_next;
  logic                   w_load;
  logic                   w_dec;
  logic                   w_last;
  logic                   w_step_go;
  logic                   w_busy;
  logic [CYCLE_WIDTH-1:0] w_cycles_next;

  step_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_step_counter (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_load   (w_load),
    .i_value  (i_step_count),
    .i_dec    (w_dec),
    .o_last   (w_last)
  );

  // A zero-length step is a no-op so a same-cycle run still gets through.
  assign w_step_go = i_step && (i_step_count != '0);
  assign w_busy    = (r_state == STATE_RUN) || (r_state == STATE_STEP);

  always_comb begin
    w_state_next = STATE_HALTED;
    w_done_next  = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    if (i_halt) begin
      w_state_next = STATE_HALTED;
    end else if (i_break) begin
      w_state_next = STATE_HALTED;
      w_done_next  = w_busy;
    end else if (w_step_go) begin
      w_state_next = STATE_STEP;
      w_load       = 1'b1;
    end else if (i_run) begin
      w_state_next = STATE_RUN;
    end else begin
      case (r_state)
        STATE_RUN: w_state_next = STATE_RUN;
        STATE_STEP: begin
          if (w_last) begin
            w_state_next = STATE_HALTED;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = STATE_STEP;
            w_dec        = 1'b1;
          end
        end
        default: w_state_next = STATE_HALTED;
      endcase
    end
  end

  always_comb begin
    w_cycles_next = r_cycles;
    if (i_clear) begin
      w_cycles_next = '0;
    end else if (r_enable) begin
      w_cycles_next = r_cycles + CYCLE_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= STATE_HALTED;
      r_enable <= 1'b0;
      r_done   <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_next;
      r_enable <= state_enables(w_state_next);
      r_done   <= w_done_next;
      r_cycles <= w_cycles_next;
    end
  end

  assign o_enable = r_enable;
  assign o_done   = r_done;
  assign o_state  = r_state;
  assign o_cycles = r_cycles;

endmodule

// File: doc/clock_controller.md
# clock_controller

Run/halt/single-step sequencer for the core clock. Accepts run, halt and N-cycle step commands from the debug front end and drives a registered clock-enable that gates the `Clock` generator's `i_enable` or the core's clock-enable tree. Also honours an external breakpoint and counts enabled cycles for the debug console.

## Interface
- `COUNT_WIDTH`, 16: width of step burst length `i_step_count`.
- `CYCLE_WIDTH`, 32: width of enabled-cycle counter `o_cycles`.

Ports:
- `i_clock` in 1: system clock; all logic on rising edge.
- `i_reset_n` in 1: reset is synchronous and active-low.
- `i_run` in 1: one-cycle command; enter RUN.
- `i_halt` in 1: one-cycle command; enter HALTED.
- `i_step` in 1: one-cycle command; enable exactly `i_step_count` cycles, then halt.
- `i_step_count` in `COUNT_WIDTH`: burst length, sampled only when `i_step` is high.
- `i_break` in 1: level breakpoint; forces HALTED and blocks run/step while high.
- `i_clear` in 1: one-cycle command; zero `o_cycles`.
- `o_enable` out 1: registered clock-enable, high iff state is RUN or STEP.
- `o_done` out 1: one-cycle pulse on step completion or break-induced halt.
- `o_state` out 2: current state encoding.
- `o_cycles` out `CYCLE_WIDTH`: count of cycles with `o_enable` high, wraps.

## Operation
- States: HALTED = 0, RUN = 1, STEP = 2. Encoding 3 is unused and decodes to HALTED next cycle.
- Per-cycle command priority, highest first: `i_halt`, `i_break`, `i_step`, `i_run`.
- `i_halt` goes to HALTED from any state. No `o_done`.
- `i_break` high in RUN or STEP: next state HALTED, `o_done` pulses. High in HALTED: stay, no pulse.
- `i_step` with N > 0 goes to STEP from any state and loads remaining = N. A step issued during STEP restarts the burst with the new N.
- `i_step` with N = 0 is ignored; the lower-priority `i_run` is still evaluated.
- `i_run` goes to RUN from HALTED or STEP. An active STEP burst is abandoned; remaining is irrelevant.
- In STEP with no higher-priority command, remaining decrements each cycle. When remaining = 1: next state HALTED, `o_done` pulses.
- `o_cycles`:
  - increments by 1 each cycle `o_enable` is high;
  - wraps from 2^`CYCLE_WIDTH`-1 to 0;
  - `i_clear` wins over a same-cycle increment, giving 0.

## Timing
- Reset values: `o_enable` = 0, `o_done` = 0, `o_state` = HALTED, `o_cycles` = 0, remaining = 0.
- Reset mid-burst or mid-run takes effect at the next edge. No `o_done` is produced.
- Command latency is 1 cycle. A command sampled at edge k changes `o_state` and `o_enable` after edge k.
- A step of N yields exactly N consecutive cycles of `o_enable` high. `o_done` is high in the first cycle `o_enable` is low again.
- Break in STEP cuts the burst short. `o_done` coincides with `o_enable` falling.
- `o_enable` is glitch-free: it is a flop output only, with no combinational path from the inputs.
- Back-to-back commands are accepted every cycle, with no busy or backpressure.

## Structure
- Shared package `clock_pkg` holds:
  - state constants `STATE_HALTED`, `STATE_RUN`, `STATE_STEP`;
  - state width constant (2).
- One sub-module: `step_counter`, a loadable down-counter (`COUNT_WIDTH`) with a `last` flag (remaining = 1). The FSM and the cycle counter stay in `clock_controller`.

## Test plan
- Reset, then `i_run` → `o_enable` high from next cycle. After 10 cycles, `i_halt` → `o_enable` low next cycle, `o_cycles` = 10, no `o_done`.
- `i_step` with N = 3 from HALTED → `o_enable` high exactly 3 cycles, `o_done` one pulse in the 4th, `o_state` back to 0, `o_cycles` +3.
- `i_step` N = 0 → no state change, no enable. `i_step` N = 5 plus `i_run` same cycle → STEP, 5 cycles.
- `i_step` N = 8 with `i_break` raised at enabled cycle 4 → 4 enable cycles, `o_done` pulses. `i_run` while `i_break` held → stays HALTED.
- Priority: `i_halt`+`i_step`+`i_run` together in RUN → HALTED. `i_clear` during RUN → `o_cycles` 0 that edge, then 1, 2, …
- `i_reset_n` low at step cycle 2 of N = 6 → all outputs at reset values next edge. Force `o_cycles` near all-ones with `CYCLE_WIDTH` = 4 → wraps 15 → 0.
